// File: rtl/burst_serializer_pkg.sv
// -----------------------------------------------------------------------------
// burst_serializer_pkg
// Shared types, default geometry and width helpers for the burst serializer.
//   state_t          : control FSM encoding (IDLE / RUN / DONE)
//   col_w / row_w    : raster counter widths, never narrower than 1 bit
//   lane_w           : lane index width inside one burst
//   bursts_per_frame : number of input beats that make up a full frame
// -----------------------------------------------------------------------------
package burst_serializer_pkg;

    localparam int DEF_PIXEL_BIT_WIDTH  = 10;
    localparam int DEF_PIXELS_PER_BURST = 4;
    localparam int DEF_IN_ROWS          = 20;
    localparam int DEF_IN_COLS          = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int col_w(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int lane_w(input int ppb);
        return (ppb > 1) ? $clog2(ppb) : 1;
    endfunction

    function automatic int bursts_per_frame(input int rows, input int cols, input int ppb);
        return (rows * cols) / ppb;
    endfunction

    localparam int BURSTS_PER_FRAME =
        bursts_per_frame(DEF_IN_ROWS, DEF_IN_COLS, DEF_PIXELS_PER_BURST);

endpackage

// File: rtl/burst_serializer_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Column/row position of the pixel currently offered on the output stream.
// Ports:
//   clk, reset (sync, active-low)
//   clear  : return to (0,0); has priority over enable
//   enable : advance one pixel (column first, wrap into next row, wrap frame)
//   col    : current column
//   row    : current row
//   last   : position is the final pixel of the frame
// -----------------------------------------------------------------------------
module raster_counter
    import burst_serializer_pkg::*;
#(
    parameter int COLS  = DEF_IN_COLS,
    parameter int ROWS  = DEF_IN_ROWS,
    parameter int COL_W = col_w(COLS),
    parameter int ROW_W = row_w(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    // Position register: explicit wrap on both axes so the counters never overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row <= '0;
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end else begin
            col <= col;
            row <= row;
        end
    end

    // Final-pixel decode of the registered position.
    always_comb begin
        last = (col == COL_LAST) && (row == ROW_LAST);
    end

endmodule

// File: rtl/burst_serializer.sv
// -----------------------------------------------------------------------------
// burst_serializer
// Takes PIXELS_PER_BURST-wide bursts from the frame grabber and emits one pixel
// per beat on an AXI-Stream master, tagged with its raster coordinates.
// One frame is produced per ap_start.
// Ports:
//   clk, reset (sync, active-low)
//   ap_start/ap_done/ap_ready/ap_idle : block-level control handshake
//   s_axis_tvalid/tready/tdata        : burst input, lane 0 in the LSBs = leftmost pixel
//   s_axis_tuser, sof_err             : only with BURST_SERIALIZER_SOF_SYNC_EN
//   m_axis_tvalid/tready/tdata/tlast  : pixel output
//   cnt_col, cnt_row                  : coordinates of the pixel on m_axis
// Build option:
//   BURST_SERIALIZER_SOF_SYNC_EN - drop bursts until one carries tuser=1, and
//   flag a sticky sof_err if tuser reappears later in the same frame.
// -----------------------------------------------------------------------------
module burst_serializer
    import burst_serializer_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = DEF_PIXEL_BIT_WIDTH,
    parameter int PIXELS_PER_BURST = DEF_PIXELS_PER_BURST,
    parameter int IN_ROWS          = DEF_IN_ROWS,
    parameter int IN_COLS          = DEF_IN_COLS
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        ap_start,
    output logic                                        ap_done,
    output logic                                        ap_ready,
    output logic                                        ap_idle,
    input  logic                                        s_axis_tvalid,
    output logic                                        s_axis_tready,
    input  logic [PIXELS_PER_BURST*PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
    input  logic                                        s_axis_tuser,
    output logic                                        sof_err,
`endif
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]                  m_axis_tdata,
    output logic                                        m_axis_tlast,
    output logic [col_w(IN_COLS)-1:0]                   cnt_col,
    output logic [row_w(IN_ROWS)-1:0]                   cnt_row
);

    localparam int LANE_W = lane_w(PIXELS_PER_BURST);
    localparam int BPF    = bursts_per_frame(IN_ROWS, IN_COLS, PIXELS_PER_BURST);
    localparam int BCNT_W = $clog2(BPF + 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIXELS_PER_BURST - 1);
    localparam logic [BCNT_W-1:0] BPF_CNT   = BCNT_W'(BPF);

    state_t state_r;
    state_t state_nxt_s;

    logic                                        run_s;
    logic                                        start_s;
    logic                                        room_s;
    logic                                        frame_full_s;
    logic                                        load_s;
    logic                                        px_hs_s;
    logic                                        last_pos_s;
    logic [PIXELS_PER_BURST*PIXEL_BIT_WIDTH-1:0] buf_r;
    logic                                        buf_valid_r;
    logic [LANE_W-1:0]                           lane_r;
    logic [BCNT_W-1:0]                           bursts_r;
    logic [PIXEL_BIT_WIDTH-1:0]                  lanes_s [PIXELS_PER_BURST];
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
    logic                                        synced_r;
    logic                                        sof_err_r;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a frame ends on the handshake of its final pixel.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (ap_start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (px_hs_s && last_pos_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: control handshake decoded from the state.
    always_comb begin
        ap_idle  = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        run_s    = 1'b0;
        case (state_r)
            IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = 1'b1;
            end
            RUN:  run_s   = 1'b1;
            DONE: ap_done = 1'b1;
            default: begin
                ap_idle  = 1'b0;
                ap_ready = 1'b0;
            end
        endcase
    end

    // Stream handshakes. The buffer may be refilled in the same cycle its last
    // lane leaves, which keeps the output gap-free at full rate. Once a whole
    // frame of bursts has been taken, further input is held off upstream.
    always_comb begin
        start_s      = (state_r == IDLE) && ap_start;
        px_hs_s      = buf_valid_r && m_axis_tready;
        room_s       = !buf_valid_r || ((lane_r == LAST_LANE) && m_axis_tready);
        frame_full_s = (bursts_r == BPF_CNT);
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
        // Before sync the buffer is empty, so bursts can be swallowed freely.
        s_axis_tready = run_s && (!synced_r || (room_s && !frame_full_s));
        load_s        = s_axis_tvalid && s_axis_tready && (synced_r || s_axis_tuser);
`else
        s_axis_tready = run_s && room_s && !frame_full_s;
        load_s        = s_axis_tvalid && s_axis_tready;
`endif
    end

    // Burst buffer and lane pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_r       <= '0;
            buf_valid_r <= 1'b0;
            lane_r      <= '0;
        end else if (load_s) begin
            buf_r       <= s_axis_tdata;
            buf_valid_r <= 1'b1;
            lane_r      <= '0;
        end else if (px_hs_s) begin
            if (lane_r == LAST_LANE) begin
                buf_valid_r <= 1'b0;
                lane_r      <= '0;
            end else begin
                lane_r      <= lane_r + LANE_W'(1);
            end
        end else begin
            buf_r       <= buf_r;
            buf_valid_r <= buf_valid_r;
            lane_r      <= lane_r;
        end
    end

    // Count of bursts loaded in the current frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bursts_r <= '0;
        end else if (start_s) begin
            bursts_r <= '0;
        end else if (load_s) begin
            bursts_r <= bursts_r + BCNT_W'(1);
        end else begin
            bursts_r <= bursts_r;
        end
    end

`ifdef BURST_SERIALIZER_SOF_SYNC_EN
    // Start-of-frame tracking: first tuser burst syncs, any later one is an error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            synced_r  <= 1'b0;
            sof_err_r <= 1'b0;
        end else if (start_s) begin
            synced_r  <= 1'b0;
            sof_err_r <= 1'b0;
        end else if (load_s) begin
            synced_r  <= 1'b1;
            sof_err_r <= sof_err_r | (synced_r & s_axis_tuser);
        end else begin
            synced_r  <= synced_r;
            sof_err_r <= sof_err_r;
        end
    end

    assign sof_err = sof_err_r;
`endif

    // Split the buffered burst into its pixel lanes.
    always_comb begin
        for (int i = 0; i < PIXELS_PER_BURST; i++) begin
            lanes_s[i] = buf_r[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
        end
    end

    // Output stream, driven straight from registered state.
    always_comb begin
        m_axis_tvalid = buf_valid_r;
        m_axis_tdata  = lanes_s[lane_r];
        m_axis_tlast  = run_s && last_pos_s && buf_valid_r;
    end

    raster_counter #(
        .COLS (IN_COLS),
        .ROWS (IN_ROWS)
    ) u_raster (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_s),
        .enable (px_hs_s),
        .col    (cnt_col),
        .row    (cnt_row),
        .last   (last_pos_s)
    );

endmodule

// File: tb/tb_burst_serializer.sv
// -----------------------------------------------------------------------------
// tb_burst_serializer
// Random-stimulus bench with a pixel scoreboard. Burst b carries pixel values
// (b*4+lane) mod 1024. Every accepted burst pushes its pixels into a queue; a
// negedge monitor pops one entry per output handshake and derives the expected
// coordinates from the pixel's index within the frame.
// -----------------------------------------------------------------------------
module tb_burst_serializer;

    localparam int PW    = 10;
    localparam int PPB   = 4;
    localparam int ROWS  = 20;
    localparam int COLS  = 20;
    localparam int TOTAL = ROWS * COLS;
    localparam int BPF   = TOTAL / PPB;

    logic              clk = 1'b0;
    logic              reset;
    logic              ap_start;
    logic              ap_done;
    logic              ap_ready;
    logic              ap_idle;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [PPB*PW-1:0] s_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [PW-1:0]     m_axis_tdata;
    logic              m_axis_tlast;
    logic [4:0]        cnt_col;
    logic [4:0]        cnt_row;
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
    logic              s_axis_tuser;
    logic              sof_err;
    int unsigned       sof_phase = 0;
    int unsigned       sof_extra = 32'hFFFF_FFFF;
    bit                mdl_synced = 1'b0;
    bit                mdl_err = 1'b0;
`endif

    always #5 clk = ~clk;

    burst_serializer dut (
        .clk           (clk),
        .reset         (reset),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_ready      (ap_ready),
        .ap_idle       (ap_idle),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
        .s_axis_tuser  (s_axis_tuser),
        .sof_err       (sof_err),
`endif
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .cnt_col       (cnt_col),
        .cnt_row       (cnt_row)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pix_val(input int unsigned b, input int unsigned l);
        return PW'((b * PPB + l) % 1024);
    endfunction

    // ---------------- stimulus: upstream bursts and downstream ready ----------
    int unsigned bnum = 0;
    bit          rand_valid = 1'b0;
    bit          rand_ready = 1'b0;
    bit          took;

    initial begin
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tdata  = '0;
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
        s_axis_tuser  = 1'b0;
`endif
        forever begin
            @(negedge clk);
            took = s_axis_tvalid && s_axis_tready && reset;
            @(posedge clk);
            #1;
            if (took) bnum++;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!s_axis_tvalid || took)
                s_axis_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int l = 0; l < PPB; l++) s_axis_tdata[l*PW +: PW] = pix_val(bnum, l);
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
            s_axis_tuser = ((bnum % BPF) == sof_phase) || (bnum == sof_extra);
`endif
        end
    end

    // ---------------- reference model + monitor --------------------------------
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_v;
    int  k_pix = 0;
    int  acc = 0;
    int  frames_done = 0;
    int  first_val = -1;
    int  first_cyc = 0;
    int  last_cyc = 0;
    int  cyc = 0;
    bit  in_frame = 1'b0;
    bit  done_pending = 1'b0;
    bit  rst_seen = 1'b0;
    bit  exp_idle;
    bit  stall_prev = 1'b0;
    int  held_data, held_last, held_col, held_row;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            exp_q.delete();
            in_frame     = 1'b0;
            k_pix        = 0;
            acc          = 0;
            done_pending = 1'b0;
            stall_prev   = 1'b0;
            rst_seen     = 1'b1;
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
            mdl_synced   = 1'b0;
            mdl_err      = 1'b0;
`endif
        end else begin
            exp_idle = !in_frame && !done_pending;
            if (rst_seen) begin
                check("rst_s_ready", s_axis_tready, 0);
                check("rst_m_valid", m_axis_tvalid, 0);
                check("rst_m_last", m_axis_tlast, 0);
                check("rst_m_data", m_axis_tdata, 0);
                check("rst_col", cnt_col, 0);
                check("rst_row", cnt_row, 0);
                rst_seen = 1'b0;
            end
            check("ap_done", ap_done, done_pending);
            check("ap_idle", ap_idle, exp_idle);
            check("ap_ready", ap_ready, exp_idle);
            if (exp_idle || acc >= BPF) check("s_ready_blocked", s_axis_tready, 0);
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
            check("sof_err", sof_err, mdl_err);
`endif
            if (stall_prev) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, held_data);
                check("hold_last", m_axis_tlast, held_last);
                check("hold_col", cnt_col, held_col);
                check("hold_row", cnt_row, held_row);
            end
            done_pending = 1'b0;

            if (m_axis_tvalid && m_axis_tready) begin
                if (!in_frame || exp_q.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("pix_data", m_axis_tdata, exp_v);
                    check("pix_col", cnt_col, k_pix % COLS);
                    check("pix_row", cnt_row, k_pix / COLS);
                    check("pix_last", m_axis_tlast, k_pix == TOTAL - 1);
                    if (k_pix == 0) begin
                        first_cyc = cyc;
                        first_val = m_axis_tdata;
                    end
                    if (k_pix == TOTAL - 1) begin
                        last_cyc     = cyc;
                        in_frame     = 1'b0;
                        done_pending = 1'b1;
                        frames_done++;
                    end
                    k_pix++;
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held_data  = m_axis_tdata;
            held_last  = m_axis_tlast;
            held_col   = cnt_col;
            held_row   = cnt_row;

            if (s_axis_tvalid && s_axis_tready) begin
                if (!in_frame || acc >= BPF) begin
                    check("over_accept", 1, 0);
                end else begin
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
                    if (mdl_synced || s_axis_tuser) begin
                        if (mdl_synced && s_axis_tuser) mdl_err = 1'b1;
                        mdl_synced = 1'b1;
                        for (int l = 0; l < PPB; l++) exp_q.push_back(pix_val(bnum, l));
                        acc++;
                    end
`else
                    for (int l = 0; l < PPB; l++) exp_q.push_back(pix_val(bnum, l));
                    acc++;
`endif
                end
            end

            if (ap_start && exp_idle) begin
                in_frame = 1'b1;
                k_pix    = 0;
                acc      = 0;
                exp_q.delete();
`ifdef BURST_SERIALIZER_SOF_SYNC_EN
                mdl_synced = 1'b0;
                mdl_err    = 1'b0;
`endif
            end
        end
    end

    // ---------------- sequence ------------------------------------------------
    task automatic pulse_start();
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (frames_done < target) check("frame_timeout", frames_done, target);
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        ap_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Frame 1: full rate, input valid already high before ap_start.
        pulse_start();
        wait_frames(1, 2000);
        check("frame1_contiguous", last_cyc - first_cyc, TOTAL - 1);
        check("frame1_first_pixel", first_val, 0);
        repeat (6) @(posedge clk);
        #1;

        // Frame 2: random valid/ready, ap_start pulses in RUN and in DONE.
        rand_valid = 1'b1;
        rand_ready = 1'b1;
        pulse_start();
        repeat (60) @(posedge clk);
        #1;
        pulse_start();
        wait_frames(2, 6000);
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        check("frames_after_ignored_start", frames_done, 2);
        check("frame2_first_pixel", first_val, 400);

        // Frame 3: reset around pixel 150, no ap_done must follow.
        pulse_start();
        n = 0;
        while (k_pix < 150 && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (k_pix < 150) check("reach_pixel_150", k_pix, 150);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("frames_after_reset", frames_done, 2);

        // Frame 4: restart from (0,0) after the reset.
        pulse_start();
        wait_frames(3, 8000);
        repeat (4) @(posedge clk);
        #1;

`ifdef BURST_SERIALIZER_SOF_SYNC_EN
        // Frame 5: three unsynced bursts dropped, second tuser on kept burst 50.
        sof_phase = (bnum + 3) % BPF;
        sof_extra = bnum + 3 + 49;
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        wait_frames(4, 8000);
        repeat (3) @(posedge clk);
        #1;
        check("sof_err_sticky", sof_err, 1);
        pulse_start();
        @(posedge clk);
        #1;
        check("sof_err_cleared", sof_err, 0);
        wait_frames(5, 8000);
        repeat (3) @(posedge clk);
        #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/burst_serializer.md
Name: burst_serializer

Overview:
- Frame-source side of the pixel pipeline. Accepts wide multi-pixel bursts from the frame grabber and emits one pixel per beat on an AXI-Stream master.
- Each pixel carries its raster coordinates cnt_col/cnt_row, feeding crop/normalize stages directly.
- Controlled by an ap_start/ap_done/ap_ready/ap_idle handshake, one frame per ap_start.

Parameters:
- PIXEL_BIT_WIDTH, 10: bits per pixel.
- PIXELS_PER_BURST, 4: pixels per input beat.
- IN_ROWS, 20: frame height.
- IN_COLS, 20: frame width; must be a multiple of PIXELS_PER_BURST.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- ap_start  in  1  start one frame; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse after the last pixel handshake.
- ap_ready  out  1  high in IDLE; can take ap_start.
- ap_idle  out  1  high in IDLE.
- s_axis_tvalid  in  1  burst valid.
- s_axis_tready  out  1  burst accepted.
- s_axis_tdata  in  PIXELS_PER_BURST*PIXEL_BIT_WIDTH  burst; lane 0 = LSBs = leftmost pixel.
- m_axis_tvalid  out  1  pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  PIXEL_BIT_WIDTH  pixel.
- m_axis_tlast  out  1  last pixel of frame.
- cnt_col  out  $clog2(IN_COLS)  column of the current m_axis pixel.
- cnt_row  out  $clog2(IN_ROWS)  row of the current m_axis pixel.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, buffer empty, lane=0, counters=0.
  - Outputs: ap_idle=1, ap_ready=1, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, cnt_col=0, cnt_row=0.
  - Reset mid-frame discards the buffered burst and any partial frame. No ap_done is issued.
- States:
  - IDLE: s_axis_tready=0. ap_start=1 -> RUN, counters cleared.
  - RUN: serialize bursts. The handshake of the pixel at (IN_ROWS-1, IN_COLS-1) -> DONE.
  - DONE: ap_done=1 for exactly one cycle -> IDLE. ap_ready/ap_idle are low in RUN and DONE.
- Buffer and handshakes:
  - One burst register plus a lane index.
  - s_axis_tready = RUN && (buffer empty || (lane==PIXELS_PER_BURST-1 && m_axis_tready)). This gives zero-bubble refill.
  - m_axis_tvalid = buffer valid; m_axis_tdata = buffer lane[lane].
- Pixel handshake (m_axis_tvalid && m_axis_tready):
  - lane increments. On the last lane the buffer empties, unless it refills in the same cycle with lane=0.
  - cnt_col increments. At IN_COLS-1 it wraps to 0 and cnt_row increments.
- Throughput and latency:
  - Sustained rate is 1 pixel/cycle when s_axis_tvalid and m_axis_tready stay high.
  - Latency is 1 cycle from burst acceptance to its lane-0 pixel on m_axis.
- Output stability: m_axis_tdata, m_axis_tlast, cnt_col and cnt_row hold stable while tvalid && !tready (AXIS rule).
- m_axis_tlast = RUN && cnt_row==IN_ROWS-1 && cnt_col==IN_COLS-1 && m_axis_tvalid.
- No over-acceptance: after the frame's last burst is accepted, s_axis_tready stays 0 until the next ap_start. Extra input beats wait in the upstream.
- ap_start is ignored outside IDLE, including when asserted in the same cycle as ap_done.
- Counter widths come from the package. No overflow is possible because the wrap is explicit.

Optional Feature:
- Macro BURST_SERIALIZER_SOF_SYNC_EN.
- Defined:
  - Adds ports s_axis_tuser (in, 1, start-of-frame on the burst) and sof_err (out, 1, sticky).
  - In RUN before sync, bursts are accepted and dropped (s_axis_tready=1, no output) until one with tuser=1 arrives. That burst becomes pixel (0,0).
  - tuser=1 on any later accepted burst of the frame sets sof_err. Its pixels are still output in place, with no resync.
  - sof_err clears on ap_start in IDLE; reset value 0.
- Undefined: no extra ports; the first burst accepted in RUN is pixel (0,0).

Decomposition:
- Package burst_serializer_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - functions for COL_W/ROW_W widths;
  - BURSTS_PER_FRAME = IN_ROWS*IN_COLS/PIXELS_PER_BURST.
- One natural sub-module, raster_counter: the col/row counter with wrap, last flag and clear/enable inputs.

Test Plan:
- Reset release, then ap_start; 100 bursts, pixel value = linear index (0..399); s_valid and m_ready always high -> 400 contiguous beats, data 0..399, col 0..19, row 0..19. tlast only on beat 399; ap_done one cycle later; ap_idle back to 1.
- Random m_axis_tready (50%) and random s_axis_tvalid -> no lost, duplicated or reordered pixels. Outputs stable while stalled; exactly 400 handshakes.
- s_axis_tvalid high before ap_start, then a 101st burst offered after the frame -> s_axis_tready=0 in IDLE and after the 100th burst; the 101st burst becomes pixel 0 of the next frame.
- reset low for one cycle at pixel 150 -> all outputs at reset values the next cycle; no ap_done. A new ap_start restarts at (0,0).
- ap_start pulsed while in RUN and while in DONE -> ignored; exactly one frame is produced.
- With BURST_SERIALIZER_SOF_SYNC_EN, feed 3 bursts with tuser=0, then tuser=1, then tuser=1 again on burst 50 -> first 3 bursts dropped, pixel 0 = first tuser burst, sof_err=1 from burst 50; cleared by the next ap_start.
